alu_cmd_ctrl: RTL

Command sequencer directly upstream of the ALU unit-select decoder. Parses ALU command frames from the UART RX byte stream, latches operands and function code, drives `ALU_FUN`/`Enable_ALU` (and the ALU clock-gate enable) until the ALU returns a valid result, then serialises the 2-byte result to the UART TX. Single clock domain (reference clock side of the system).

---
 rtl/alu_cmd_ctrl.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl: parses ALU command frames from the UART RX byte stream,
// drives the ALU until it reports a result (or times out), then sends the
// two result bytes to the UART TX, low byte first.
//   0xCC A B FUN : load both operands and the function code, run the ALU
//   0xDD FUN     : reuse the held operands with a new function code
module alu_cmd_ctrl #(
   parameter int DATA_WIDTH = 8,
   parameter int FUN_WIDTH  = 4,
   parameter int TIMEOUT    = 15
) (
   input  logic                      CLK,
   input  logic                      RST,
   input  logic [DATA_WIDTH-1:0]     RX_P_DATA,
   input  logic                      RX_D_VLD,
   input  logic [2*DATA_WIDTH-1:0]   ALU_OUT,
   input  logic                      ALU_OUT_VLD,
   input  logic                      TX_Busy,
   output logic [DATA_WIDTH-1:0]     ALU_A,
   output logic [DATA_WIDTH-1:0]     ALU_B,
   output logic [FUN_WIDTH-1:0]      ALU_FUN,
   output logic                      Enable_ALU,
   output logic                      Gate_EN,
   output logic [DATA_WIDTH-1:0]     TX_P_DATA,
   output logic                      TX_D_VLD,
   output logic                      Cmd_Err,
   output logic                      Ctrl_Busy
);

   localparam int                    CNT_W     = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0]      TO_VAL    = CNT_W'(TIMEOUT);
   localparam logic [DATA_WIDTH-1:0] CMD_NEW   = DATA_WIDTH'(8'hCC);
   localparam logic [DATA_WIDTH-1:0] CMD_REUSE = DATA_WIDTH'(8'hDD);

   typedef enum logic [2:0] {
      IDLE,
      GET_A,
      GET_B,
      GET_FUN,
      ALU_RUN,
      SEND_LO,
      WAIT_LO,
      SEND_HI
   } state_t;

   state_t                  r_state;
   logic [CNT_W-1:0]        r_cnt;
   logic [2*DATA_WIDTH-1:0] r_result;

   // Frame sequencer: every output is a register updated alongside the state,
   // so nothing combinational reaches the ports from the inputs.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state    <= IDLE;
         r_cnt      <= '0;
         r_result   <= '0;
         ALU_A      <= '0;
         ALU_B      <= '0;
         ALU_FUN    <= '0;
         Enable_ALU <= 1'b0;
         Gate_EN    <= 1'b0;
         TX_P_DATA  <= '0;
         TX_D_VLD   <= 1'b0;
         Cmd_Err    <= 1'b0;
         Ctrl_Busy  <= 1'b0;
      end else begin
         TX_D_VLD <= 1'b0;
         Cmd_Err  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (RX_D_VLD) begin
                  if (RX_P_DATA == CMD_NEW) begin
                     r_state   <= GET_A;
                     Ctrl_Busy <= 1'b1;
                  end else if (RX_P_DATA == CMD_REUSE) begin
                     r_state   <= GET_FUN;
                     Ctrl_Busy <= 1'b1;
                  end
               end
            end
            GET_A: begin
               if (RX_D_VLD) begin
                  ALU_A   <= RX_P_DATA;
                  r_state <= GET_B;
               end
            end
            GET_B: begin
               if (RX_D_VLD) begin
                  ALU_B   <= RX_P_DATA;
                  r_state <= GET_FUN;
               end
            end
            GET_FUN: begin
               if (RX_D_VLD) begin
                  ALU_FUN    <= RX_P_DATA[FUN_WIDTH-1:0];
                  r_cnt      <= '0;
                  Enable_ALU <= 1'b1;
                  Gate_EN    <= 1'b1;
                  r_state    <= ALU_RUN;
               end
            end
            ALU_RUN: begin
               // A valid result takes priority over an expiring timeout
               if (ALU_OUT_VLD) begin
                  r_result   <= ALU_OUT;
                  Enable_ALU <= 1'b0;
                  Gate_EN    <= 1'b0;
                  r_state    <= SEND_LO;
               end else if (r_cnt == TO_VAL) begin
                  Cmd_Err    <= 1'b1;
                  Enable_ALU <= 1'b0;
                  Gate_EN    <= 1'b0;
                  Ctrl_Busy  <= 1'b0;
                  r_state    <= IDLE;
               end else begin
                  r_cnt <= r_cnt + CNT_W'(1);
               end
            end
            SEND_LO: begin
               if (!TX_Busy) begin
                  TX_P_DATA <= r_result[DATA_WIDTH-1:0];
                  TX_D_VLD  <= 1'b1;
                  r_state   <= WAIT_LO;
               end
            end
            WAIT_LO: begin
               // Hold until TX acknowledges the low byte by going busy
               if (TX_Busy) begin
                  r_state <= SEND_HI;
               end
            end
            SEND_HI: begin
               if (!TX_Busy) begin
                  TX_P_DATA <= r_result[2*DATA_WIDTH-1:DATA_WIDTH];
                  TX_D_VLD  <= 1'b1;
                  Ctrl_Busy <= 1'b0;
                  r_state   <= IDLE;
               end
            end
            default: begin
               Enable_ALU <= 1'b0;
               Gate_EN    <= 1'b0;
               Ctrl_Busy  <= 1'b0;
               r_state    <= IDLE;
            end
         endcase
      end
   end

endmodule
